// File: rtl/if_stage.sv
// rtl/if_stage.sv - MIPS instruction-fetch stage: PC, ROM fetch and IF/ID register
//
// Holds the program counter and presents it to the instruction ROM. Picks the next
// PC from the sequential, branch-redirect and flush sources, then registers the
// fetched instruction and its PC into the IF/ID pipeline register.
//
// Ports:
//   clk, rst              clock (rising edge), asynchronous active-low reset
//   stall                 hold PC and IF/ID
//   flush, flush_pc       exception/eret redirect; IF/ID gets a bubble
//   branch_flag/_target   taken branch/jump resolved in decode
//   inst_rom_data         instruction read combinationally at inst_rom_addr
//   inst_rom_addr/_ce     fetch address (current PC) and ROM chip enable
//   id_pc/_inst/_valid    IF/ID register contents; valid=0 marks a bubble
//   id_adel               fetch address of the IF/ID instruction was misaligned
module if_stage #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter bit          DELAY_SLOT = 1'b1,
  parameter logic [31:0] NOP_INST   = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        flush,
  input  logic [31:0] flush_pc,
  input  logic        branch_flag,
  input  logic [31:0] branch_target,
  input  logic [31:0] inst_rom_data,
  output logic [31:0] inst_rom_addr,
  output logic        inst_rom_ce,
  output logic [31:0] id_pc,
  output logic [31:0] id_inst,
  output logic        id_valid,
  output logic        id_adel
);

  typedef enum logic {
    IDLE  = 1'b0,
    FETCH = 1'b1
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic        ce_q, ce_d;
  logic [31:0] id_pc_q, id_pc_d;
  logic [31:0] id_inst_q, id_inst_d;
  logic        id_valid_q, id_valid_d;
  logic        id_adel_q, id_adel_d;

  logic load_real;
  logic load_bubble;
  logic pc_misaligned;

  assign pc_misaligned = (pc_q[1:0] != 2'b00);

  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    ce_d        = ce_q;
    id_pc_d     = id_pc_q;
    id_inst_d   = id_inst_q;
    id_valid_d  = id_valid_q;
    id_adel_d   = id_adel_q;
    load_real   = 1'b0;
    load_bubble = 1'b0;

    if (state_q == IDLE) begin
      // First edge after reset only enables the ROM; the PC stays at RESET_PC
      // so the first real fetch happens from it on the following edge.
      state_d     = FETCH;
      ce_d        = 1'b1;
      load_bubble = 1'b1;
    end else if (flush) begin
      pc_d        = flush_pc;
      load_bubble = 1'b1;
    end else if (!stall) begin
      // A stalled decode keeps branch_flag high, so ignoring it while stalled
      // simply defers the redirect to the first unstalled edge.
      if (branch_flag) begin
        pc_d = branch_target;
        if (DELAY_SLOT) load_real = 1'b1;
        else            load_bubble = 1'b1;
      end else begin
        pc_d      = pc_q + 32'd4;
        load_real = 1'b1;
      end
    end

    if (load_bubble) begin
      id_pc_d    = 32'h0000_0000;
      id_inst_d  = NOP_INST;
      id_valid_d = 1'b0;
      id_adel_d  = 1'b0;
    end else if (load_real) begin
      // A misaligned fetch stays valid so exception logic sees the faulting PC,
      // but its instruction word is meaningless and is replaced by a NOP.
      id_pc_d    = pc_q;
      id_inst_d  = pc_misaligned ? NOP_INST : inst_rom_data;
      id_valid_d = 1'b1;
      id_adel_d  = pc_misaligned;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      pc_q       <= RESET_PC;
      ce_q       <= 1'b0;
      id_pc_q    <= 32'h0000_0000;
      id_inst_q  <= NOP_INST;
      id_valid_q <= 1'b0;
      id_adel_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      ce_q       <= ce_d;
      id_pc_q    <= id_pc_d;
      id_inst_q  <= id_inst_d;
      id_valid_q <= id_valid_d;
      id_adel_q  <= id_adel_d;
    end
  end

  assign inst_rom_addr = pc_q;
  assign inst_rom_ce   = ce_q;
  assign id_pc         = id_pc_q;
  assign id_inst       = id_inst_q;
  assign id_valid      = id_valid_q;
  assign id_adel       = id_adel_q;

endmodule

// File: tb/tb_if_stage.sv
// tb/tb_if_stage.sv - self-checking bench for if_stage, both delay-slot variants
module tb_if_stage;

  localparam logic [31:0] NOP0 = 32'h0000_0000;
  localparam logic [31:0] NOP1 = 32'h0000_0C0D;

  logic        clk;
  logic        rst;
  logic        stall;
  logic        flush;
  logic [31:0] flush_pc;
  logic        branch_flag;
  logic [31:0] branch_target;

  logic [31:0] rom_data [2];
  logic [31:0] rom_addr [2];
  logic        rom_ce   [2];
  logic [31:0] o_id_pc  [2];
  logic [31:0] o_id_inst[2];
  logic        o_id_valid[2];
  logic        o_id_adel [2];

  int checks;
  int errors;

  // Reference state: one entry per instance (0: delay slot, 1: no delay slot)
  bit          m_fetch [2];
  logic [31:0] m_pc    [2];
  logic [31:0] m_id_pc [2];
  logic [31:0] m_id_inst[2];
  bit          m_valid [2];
  bit          m_adel  [2];

  function automatic logic [31:0] rom_f(input logic [31:0] a);
    return {a[15:0], ~a[15:0]} ^ 32'h1357_9BDF;
  endfunction

  function automatic logic [31:0] nop_of(input int k);
    return (k == 0) ? NOP0 : NOP1;
  endfunction

  assign rom_data[0] = rom_f(rom_addr[0]);
  assign rom_data[1] = rom_f(rom_addr[1]);

  if_stage #(.RESET_PC(32'h0), .DELAY_SLOT(1'b1), .NOP_INST(NOP0)) u_ds1 (
    .clk(clk), .rst(rst), .stall(stall), .flush(flush), .flush_pc(flush_pc),
    .branch_flag(branch_flag), .branch_target(branch_target),
    .inst_rom_data(rom_data[0]), .inst_rom_addr(rom_addr[0]), .inst_rom_ce(rom_ce[0]),
    .id_pc(o_id_pc[0]), .id_inst(o_id_inst[0]), .id_valid(o_id_valid[0]), .id_adel(o_id_adel[0])
  );

  if_stage #(.RESET_PC(32'h0), .DELAY_SLOT(1'b0), .NOP_INST(NOP1)) u_ds0 (
    .clk(clk), .rst(rst), .stall(stall), .flush(flush), .flush_pc(flush_pc),
    .branch_flag(branch_flag), .branch_target(branch_target),
    .inst_rom_data(rom_data[1]), .inst_rom_addr(rom_addr[1]), .inst_rom_ce(rom_ce[1]),
    .id_pc(o_id_pc[1]), .id_inst(o_id_inst[1]), .id_valid(o_id_valid[1]), .id_adel(o_id_adel[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_fetch[k]   = 1'b0;
      m_pc[k]      = 32'h0;
      m_id_pc[k]   = 32'h0;
      m_id_inst[k] = nop_of(k);
      m_valid[k]   = 1'b0;
      m_adel[k]    = 1'b0;
    end
  endtask

  task automatic model_bubble(input int k);
    m_id_pc[k]   = 32'h0;
    m_id_inst[k] = nop_of(k);
    m_valid[k]   = 1'b0;
    m_adel[k]    = 1'b0;
  endtask

  task automatic model_take(input int k);
    m_id_pc[k]   = m_pc[k];
    m_adel[k]    = (m_pc[k] % 4) != 0;
    m_id_inst[k] = m_adel[k] ? nop_of(k) : rom_f(m_pc[k]);
    m_valid[k]   = 1'b1;
  endtask

  // One rising edge of the pipeline as described by the next-PC priority list
  task automatic model_edge();
    for (int k = 0; k < 2; k++) begin
      if (!m_fetch[k]) begin
        m_fetch[k] = 1'b1;
        model_bubble(k);
      end else if (flush) begin
        m_pc[k] = flush_pc;
        model_bubble(k);
      end else if (stall) begin
        // everything holds
      end else if (branch_flag) begin
        if (k == 0) model_take(k);
        else        model_bubble(k);
        m_pc[k] = branch_target;
      end else begin
        model_take(k);
        m_pc[k] = 32'((64'(m_pc[k]) + 64'd4) % 64'h1_0000_0000);
      end
    end
  endtask

  task automatic check_all(input string tag);
    for (int k = 0; k < 2; k++) begin
      check($sformatf("%s/i%0d/addr", tag, k),  rom_addr[k],         m_pc[k]);
      check($sformatf("%s/i%0d/ce", tag, k),    32'(rom_ce[k]),      32'(m_fetch[k]));
      check($sformatf("%s/i%0d/id_pc", tag, k), o_id_pc[k],          m_id_pc[k]);
      check($sformatf("%s/i%0d/inst", tag, k),  o_id_inst[k],        m_id_inst[k]);
      check($sformatf("%s/i%0d/valid", tag, k), 32'(o_id_valid[k]),  32'(m_valid[k]));
      check($sformatf("%s/i%0d/adel", tag, k),  32'(o_id_adel[k]),   32'(m_adel[k]));
    end
  endtask

  // Called with inputs already set at a falling edge; returns at the next falling edge.
  task automatic step(input string tag);
    @(posedge clk);
    #1;
    model_edge();
    check_all(tag);
    @(negedge clk);
  endtask

  task automatic set_in(input bit s, input bit f, input logic [31:0] fpc,
                        input bit b, input logic [31:0] bt);
    stall = s; flush = f; flush_pc = fpc; branch_flag = b; branch_target = bt;
  endtask

  // Reset asserted between edges: outputs must clear without any clock edge.
  task automatic async_reset(input string tag);
    #2;
    rst = 1'b0;
    #1;
    model_reset();
    check_all({tag, "/now"});
    @(posedge clk);
    #1;
    check_all({tag, "/held"});
    @(negedge clk);
    rst = 1'b1;
  endtask

  initial begin
    logic [31:0] tgt;
    logic [31:0] fpc;
    checks = 0;
    errors = 0;
    rst = 1'b0;
    set_in(0, 0, 32'h0, 0, 32'h0);
    model_reset();
    #28;
    check_all("reset");
    @(negedge clk);
    rst = 1'b1;

    step("idle_to_fetch");
    step("fetch_A");
    step("fetch_B");

    // redirect while pc=8: delay-slot variant keeps the instruction at 8
    set_in(0, 0, 32'h0, 1, 32'h40);
    step("branch");
    set_in(0, 0, 32'h0, 0, 32'h0);
    step("after_branch");

    // move to 0x10, then stall three edges with a pending branch
    set_in(0, 0, 32'h0, 1, 32'h10);
    step("to_10");
    set_in(1, 0, 32'h0, 1, 32'h200);
    for (int i = 0; i < 3; i++) step($sformatf("stall%0d", i));
    set_in(0, 0, 32'h0, 1, 32'h200);
    step("unstall_branch");

    // flush overrides stall and branch; then fetch from a misaligned target
    set_in(1, 1, 32'h180, 1, 32'h300);
    step("flush_all");
    set_in(0, 0, 32'h0, 1, 32'h42);
    step("to_42");
    set_in(0, 0, 32'h0, 0, 32'h0);
    step("fetch_42");
    set_in(0, 0, 32'h0, 1, 32'h20);
    step("to_20");

    set_in(0, 0, 32'h0, 0, 32'h0);
    async_reset("arst_20");
    step("rerun_idle");

    // PC wraps from the top of the address space to zero
    set_in(0, 0, 32'h0, 1, 32'hFFFF_FFFC);
    step("to_top");
    set_in(0, 0, 32'h0, 0, 32'h0);
    step("wrap");
    step("after_wrap");

    for (int n = 0; n < 400; n++) begin
      tgt = $urandom;
      fpc = $urandom;
      if ($urandom_range(0, 7) != 0) tgt[1:0] = 2'b00;
      if ($urandom_range(0, 7) != 0) fpc[1:0] = 2'b00;
      set_in(($urandom_range(0, 3) == 0), ($urandom_range(0, 19) == 0), fpc,
             ($urandom_range(0, 4) == 0), tgt);
      if ($urandom_range(0, 99) == 0) async_reset("rnd_arst");
      else step("rnd");
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
